// File: rtl/id_stage_reg.sv
// ID/EX pipeline register: one-cycle capture of decode fields with flush/freeze control,
// saturating bubble counter and a sticky illegal-control flag.
module id_stage_reg #(
    parameter int WORD = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            freeze,
    input  logic            valid_in,
    input  logic [3:0]      exec_cmd_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic            wb_en_in,
    input  logic            branch_in,
    input  logic            s_in,
    input  logic [WORD-1:0] pc_in,
    input  logic [WORD-1:0] val_rn_in,
    input  logic [WORD-1:0] val_rm_in,
    input  logic            imm_in,
    input  logic [11:0]     shift_operand_in,
    input  logic [23:0]     signed_imm24_in,
    input  logic [3:0]      dest_in,
    input  logic [3:0]      src1_in,
    input  logic [3:0]      src2_in,
    input  logic [3:0]      status_in,
    output logic [3:0]      exec_cmd_out,
    output logic            mem_read_out,
    output logic            mem_write_out,
    output logic            wb_en_out,
    output logic            branch_out,
    output logic            s_out,
    output logic [WORD-1:0] pc_out,
    output logic [WORD-1:0] val_rn_out,
    output logic [WORD-1:0] val_rm_out,
    output logic            imm_out,
    output logic [11:0]     shift_operand_out,
    output logic [23:0]     signed_imm24_out,
    output logic [3:0]      dest_out,
    output logic [3:0]      src1_out,
    output logic [3:0]      src2_out,
    output logic [3:0]      status_out,
    output logic            valid_out,
    output logic [15:0]     bubble_cnt,
    output logic            ctrl_err
);

    localparam int FW = 4 + 5 + 3 * WORD + 1 + 12 + 24 + 4 * 4;

    logic [FW-1:0] w_fields_in;
    logic          w_bubble;
    logic          w_capture;

    logic [FW-1:0] r_fields;
    logic          r_valid;
    logic [15:0]   r_bubble_cnt;
    logic          r_ctrl_err;

    // status rides with exec_cmd/s so the EX carry matches the issuing cycle
    assign w_fields_in = {exec_cmd_in, mem_read_in, mem_write_in, wb_en_in, branch_in, s_in,
                          pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
                          signed_imm24_in, dest_in, src1_in, src2_in, status_in};

    assign w_bubble  = flush | (~freeze & ~valid_in);
    assign w_capture = ~flush & ~freeze & valid_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fields     <= '0;
            r_valid      <= 1'b0;
            r_bubble_cnt <= 16'h0000;
            r_ctrl_err   <= 1'b0;
        end else if (w_bubble) begin
            r_fields <= '0;
            r_valid  <= 1'b0;
            if (r_bubble_cnt != 16'hFFFF) begin
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end
        end else if (w_capture) begin
            r_fields <= w_fields_in;
            r_valid  <= 1'b1;
            if (mem_read_in && mem_write_in) begin
                r_ctrl_err <= 1'b1;
            end
        end
    end

    assign {exec_cmd_out, mem_read_out, mem_write_out, wb_en_out, branch_out, s_out,
            pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
            signed_imm24_out, dest_out, src1_out, src2_out, status_out} = r_fields;

    assign valid_out  = r_valid;
    assign bubble_cnt = r_bubble_cnt;
    assign ctrl_err   = r_ctrl_err;

endmodule
